serial_subtractor_ctrl: RTL and testbench

//  Bit-serial N-bit subtractor controller (result = a - b).
//  - Latches two operands on start and feeds one bit pair per clock, LSB first, into a single full_subtractor cell.
//  - Registers each cell's borrow as the next cycle's bin.
//  - Shifts each diff bit into the result register.
//  - Sits directly upstream of the full_subtractor cell and consumes its diff/bout outputs.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 14 +
 rtl/serial_subtractor_ctrl_fs.sv | 18 +
 rtl/serial_subtractor_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_sub_pkg: shared types and defaults for the bit-serial subtractor.
//   sub_state_t           controller state encoding (IDLE, SHIFT, DONE)
//   SERIAL_SUB_DEFAULT_N  default operand/result width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_t;

    localparam int SERIAL_SUB_DEFAULT_N = 4;

endpackage

// File: rtl/serial_subtractor_ctrl_fs.sv
// full_subtractor: single-bit subtractor cell, diff = a - b - bin.
// Ports:
//   i_a, i_b, i_bin  minuend bit, subtrahend bit, borrow in
//   o_diff           difference bit
//   o_bout           borrow out
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    // Borrow when b exceeds a, or when they match and a borrow is pending.
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial N-bit subtractor, result = a - b.
// Operands are latched on an accepted start and fed LSB first, one bit pair
// per clock, through one full_subtractor cell. The cell's borrow is
// registered as the next bit's borrow in; diff bits shift into the result
// from the MSB end so the result is aligned after N shifts.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds o_ovf, signed overflow).
// Ports:
//   i_clk, i_rst_n   clock (rising edge), synchronous active-low reset
//   i_start          request, accepted only in IDLE
//   i_a, i_b         minuend / subtrahend, sampled on accepted start
//   o_busy           high while shifting
//   o_done           one-cycle pulse, result/borrow valid
//   o_result         a - b modulo 2^N
//   o_borrow_out     1 when a < b (unsigned)
//   o_ovf            signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int N = SERIAL_SUB_DEFAULT_N
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_result,
`ifdef SERIAL_SUB_OVF_EN
    output logic         o_ovf,
`endif
    output logic         o_borrow_out
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    sub_state_t         r_state;
    sub_state_t         w_next;
    logic [N-1:0]       r_a_sh;
    logic [N-1:0]       r_b_sh;
    logic [N-1:0]       r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_brw;
    logic               r_borrow_out;
    logic               w_diff;
    logic               w_bout;
    logic               w_last;

    full_subtractor u_fs (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_brw),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // Final bit pair is on the cell during the last SHIFT cycle.
    assign w_last = (r_state == SHIFT) && (r_cnt == CNT_W'(N - 1));

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            IDLE:  if (i_start) w_next = SHIFT;
            SHIFT: begin
                o_busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE:  begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_result     <= '0;
            r_cnt        <= '0;
            r_brw        <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_a_sh <= i_a;
                r_b_sh <= i_b;
                r_brw  <= 1'b0;
                r_cnt  <= '0;
            end else if (r_state == SHIFT) begin
                r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
                r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
                r_result <= {w_diff, r_result[N-1:1]};
                r_brw    <= w_bout;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) r_borrow_out <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)    r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_brw ^ w_bout;
    end

    assign o_ovf = r_ovf;
`endif

    assign o_result     = r_result;
    assign o_borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] a4, b4, res4;
    logic [7:0] a8, b8, res8;
    logic       busy4, done4, brw4, ovf4;
    logic       busy8, done8, brw8, ovf8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.N(4)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start4),
        .i_a          (a4),
        .i_b          (b4),
        .o_busy       (busy4),
        .o_done       (done4),
        .o_result     (res4),
`ifdef SERIAL_SUB_OVF_EN
        .o_ovf        (ovf4),
`endif
        .o_borrow_out (brw4)
    );

    serial_subtractor_ctrl #(.N(8)) dut8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start8),
        .i_a          (a8),
        .i_b          (b8),
        .o_busy       (busy8),
        .o_done       (done8),
        .o_result     (res8),
`ifdef SERIAL_SUB_OVF_EN
        .o_ovf        (ovf8),
`endif
        .o_borrow_out (brw8)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf4 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       brw;
        logic       ovf;
        string      name;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One N=4 operation: start at cycle 0, busy cycles 1..4, done at cycle 5.
    task automatic op4(input vec_t v);
        bit busy_ok;
        busy_ok = 1'b1;
        @(negedge clk);
        start4 = 1'b1; a4 = v.a; b4 = v.b;
        @(negedge clk);
        start4 = 1'b0; a4 = '0; b4 = '0;
        for (int k = 1; k <= 4; k++) begin
            if (!(busy4 === 1'b1 && done4 === 1'b0)) busy_ok = 1'b0;
            @(negedge clk);
        end
        chk({v.name, " busy_1to4"}, 32'(busy_ok), 32'd1);
        chk({v.name, " done_c5"}, 32'(done4), 32'd1);
        chk({v.name, " result"}, 32'(res4), 32'(v.res));
        chk({v.name, " borrow"}, 32'(brw4), 32'(v.brw));
`ifdef SERIAL_SUB_OVF_EN
        chk({v.name, " ovf"}, 32'(ovf4), 32'(v.ovf));
`endif
    endtask

    // One N=8 operation against an independent arithmetic model.
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [8:0] full;
        full = {1'b0, a} - {1'b0, b};
        lat = -1;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("n8 %0d-%0d latency", a, b), 32'(lat), 32'd9);
        chk($sformatf("n8 %0d-%0d result", a, b), 32'(res8), 32'(full[7:0]));
        chk($sformatf("n8 %0d-%0d borrow", a, b), 32'(brw8), 32'(a < b));
`ifdef SERIAL_SUB_OVF_EN
        chk($sformatf("n8 %0d-%0d ovf", a, b), 32'(ovf8),
            32'((a[7] != b[7]) && (full[7] != a[7])));
`endif
    endtask

    initial begin
        int dones;
        tv[0] = '{4'd5,    4'd3,    4'b0010, 1'b0, 1'b0, "5-3"};
        tv[1] = '{4'd3,    4'd5,    4'b1110, 1'b1, 1'b0, "3-5"};
        tv[2] = '{4'd0,    4'd0,    4'd0,    1'b0, 1'b0, "0-0"};
        tv[3] = '{4'd15,   4'd0,    4'd15,   1'b0, 1'b0, "15-0"};
        tv[4] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, "8-1"};
        tv[5] = '{4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0, "3-1"};

        rst_n = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset result", 32'(res4), 32'd0);
        chk("reset borrow", 32'(brw4), 32'd0);
        chk("reset ovf", 32'(ovf4), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) op4(tv[i]);

        // start held high through SHIFT and DONE: one op only, DONE -> IDLE.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd4;
        dones = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            a4 = '0; b4 = '0;
            if (done4 === 1'b1) dones++;
            if (k == 5) chk("held start result", 32'(res4), 32'd5);
        end
        chk("held start idle c6", 32'(busy4), 32'd0);
        start4 = 1'b0;
        @(negedge clk);
        chk("held start idle c7", 32'(busy4), 32'd0);
        chk("held start single done", 32'(dones), 32'd1);

        // Reset for one edge at cycle 2 of an operation aborts it.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort result", 32'(res4), 32'd0);
        chk("abort borrow", 32'(brw4), 32'd0);
        chk("abort ovf", 32'(ovf4), 32'd0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done4 === 1'b1) dones++;
            @(negedge clk);
        end
        chk("abort no done", 32'(dones), 32'd0);

        op4(tv[0]);

        op8(8'd0, 8'd0);
        op8(8'd255, 8'd0);
        op8(8'd0, 8'd255);
        op8(8'd255, 8'd255);
        op8(8'd128, 8'd1);
        for (int i = 0; i < 150; i++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
